// File: rtl/clock_div_monitor.sv
// clock_div_monitor: checks a divided clock against its expected division factor.
// The monitored clock is sampled in the clk_in domain. Each rising edge captures the
// period and high time, which drive lock tracking, a saturating error count and a
// sticky stall fault.
module clock_div_monitor #(
    parameter int cfactor = 4,
    parameter int TOL     = 0,
    parameter int LOCK_N  = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk_in,
    input  logic             rst_x,
    input  logic             clk_mon,
    input  logic             clr,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             meas_vld,
    output logic             lock,
    output logic             fault,
    output logic [7:0]       err_cnt
);

    localparam logic [CNT_W-1:0] MAX    = '1;
    localparam logic [CNT_W-1:0] CF     = CNT_W'(cfactor);
    localparam logic [CNT_W-1:0] HALF   = CNT_W'(cfactor / 2);
    localparam logic [CNT_W-1:0] TOLV   = CNT_W'(TOL);
    localparam logic [3:0]       LOCK_V = 4'(LOCK_N);

    typedef enum logic [1:0] {
        IDLE,
        MEAS,
        LOCK
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       good_cnt;
    logic [3:0]       good_nxt;
    logic             s1;
    logic             s2;
    logic             s3;
    logic             rise;
    logic [CNT_W-1:0] per_cnt;
    logic [CNT_W-1:0] hi_cnt;
    logic [CNT_W-1:0] per_dev;
    logic [CNT_W-1:0] hi_dev;
    logic             good;
    logic             capture;
    logic             bad_evt;
    logic             tmo_evt;
    logic             err_evt;

    // Synchronizer plus edge-history flop; reset high so a high clk_mon at release is not an edge
    always_ff @(posedge clk_in or negedge rst_x) begin
        if (!rst_x) begin
            s1 <= 1'b1;
            s2 <= 1'b1;
            s3 <= 1'b1;
        end else begin
            s1 <= clk_mon;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

    // Period and high-time counters, restarted by every rise and saturating at MAX
    always_ff @(posedge clk_in or negedge rst_x) begin
        if (!rst_x) begin
            per_cnt <= '0;
            hi_cnt  <= '0;
        end else if (rise) begin
            per_cnt <= CNT_W'(1);
            hi_cnt  <= CNT_W'(1);
        end else begin
            if (per_cnt != MAX) begin
                per_cnt <= per_cnt + CNT_W'(1);
            end
            if (s2 && (hi_cnt != MAX)) begin
                hi_cnt <= hi_cnt + CNT_W'(1);
            end
        end
    end

    // Absolute deviations of the running counts from the expected period and high time
    always_comb begin
        per_dev = (per_cnt >= CF)   ? (per_cnt - CF)   : (CF - per_cnt);
        hi_dev  = (hi_cnt  >= HALF) ? (hi_cnt  - HALF) : (HALF - hi_cnt);
        good    = (per_dev <= TOLV) && (hi_dev <= TOLV);
    end

    // State register and consecutive-good counter
    always_ff @(posedge clk_in or negedge rst_x) begin
        if (!rst_x) begin
            state    <= IDLE;
            good_cnt <= '0;
        end else begin
            state    <= state_nxt;
            good_cnt <= good_nxt;
        end
    end

    // Next-state logic: a rise captures (outside IDLE); a saturated period counter is a stall
    always_comb begin
        state_nxt = state;
        good_nxt  = good_cnt;
        capture   = 1'b0;
        bad_evt   = 1'b0;
        tmo_evt   = 1'b0;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_nxt = MEAS;
                end
            end
            MEAS: begin
                if (rise) begin
                    capture = 1'b1;
                    if (good) begin
                        good_nxt = good_cnt + 4'd1;
                        if (good_cnt == LOCK_V - 4'd1) begin
                            state_nxt = LOCK;
                        end
                    end else begin
                        good_nxt = '0;
                        bad_evt  = 1'b1;
                    end
                end else if (per_cnt == MAX) begin
                    tmo_evt   = 1'b1;
                    good_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            LOCK: begin
                if (rise) begin
                    capture = 1'b1;
                    if (!good) begin
                        good_nxt  = '0;
                        bad_evt   = 1'b1;
                        state_nxt = MEAS;
                    end
                end else if (per_cnt == MAX) begin
                    tmo_evt   = 1'b1;
                    good_nxt  = '0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                good_nxt  = '0;
            end
        endcase
    end

    assign err_evt = bad_evt | tmo_evt;

    // Registered outputs: captures, lock flag, error counter (events beat clr) and sticky fault
    always_ff @(posedge clk_in or negedge rst_x) begin
        if (!rst_x) begin
            period    <= '0;
            high_time <= '0;
            meas_vld  <= 1'b0;
            lock      <= 1'b0;
            fault     <= 1'b0;
            err_cnt   <= '0;
        end else begin
            meas_vld <= capture;
            lock     <= (state_nxt == LOCK);
            if (capture) begin
                period    <= per_cnt;
                high_time <= hi_cnt;
            end
            if (err_evt) begin
                if (clr) begin
                    err_cnt <= 8'd1;
                end else if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end else if (clr) begin
                err_cnt <= '0;
            end
            if (tmo_evt) begin
                fault <= 1'b1;
            end else if (clr) begin
                fault <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_clock_div_monitor.sv
// tb_clock_div_monitor: directed scenarios for clock_div_monitor.
// Instance u_dut4 uses the default factor of 4 and instance u_dut5 uses a factor of 5.
module tb_clock_div_monitor;

    logic       clk_in;
    logic       rst_x;
    logic       clk_mon4;
    logic       clk_mon5;
    logic       clr4;
    logic       clr5;
    logic [7:0] period4;
    logic [7:0] high_time4;
    logic       meas_vld4;
    logic       lock4;
    logic       fault4;
    logic [7:0] err_cnt4;
    logic [7:0] period5;
    logic [7:0] high_time5;
    logic       meas_vld5;
    logic       lock5;
    logic       fault5;
    logic [7:0] err_cnt5;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_cap4 = 0;

    typedef struct {
        logic [7:0] per;
        logic [7:0] hi;
        logic       lk;
        logic [7:0] err;
        int         cyc;
    } cap_t;

    cap_t q4[$];
    cap_t q5[$];

    clock_div_monitor #(.cfactor(4), .TOL(0), .LOCK_N(4), .CNT_W(8)) u_dut4 (
        .clk_in    (clk_in),
        .rst_x     (rst_x),
        .clk_mon   (clk_mon4),
        .clr       (clr4),
        .period    (period4),
        .high_time (high_time4),
        .meas_vld  (meas_vld4),
        .lock      (lock4),
        .fault     (fault4),
        .err_cnt   (err_cnt4)
    );

    clock_div_monitor #(.cfactor(5), .TOL(0), .LOCK_N(4), .CNT_W(8)) u_dut5 (
        .clk_in    (clk_in),
        .rst_x     (rst_x),
        .clk_mon   (clk_mon5),
        .clr       (clr5),
        .period    (period5),
        .high_time (high_time5),
        .meas_vld  (meas_vld5),
        .lock      (lock5),
        .fault     (fault5),
        .err_cnt   (err_cnt5)
    );

    // Source clock
    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    // Cycle counter for capture spacing and stall timing
    always @(posedge clk_in) begin
        cyc <= cyc + 1;
    end

    // Record every capture shortly after the edge that produced it
    always @(posedge clk_in) begin
        cap_t c;
        #1;
        if (meas_vld4 === 1'b1) begin
            c.per = period4; c.hi = high_time4; c.lk = lock4; c.err = err_cnt4; c.cyc = cyc;
            q4.push_back(c);
            last_cap4 = cyc;
        end
        if (meas_vld5 === 1'b1) begin
            c.per = period5; c.hi = high_time5; c.lk = lock5; c.err = err_cnt5; c.cyc = cyc;
            q5.push_back(c);
        end
    end

    task automatic tick4(input logic v);
        @(negedge clk_in);
        clk_mon4 = v;
    endtask

    task automatic run4(input int n, input int div, input int hi);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < div; c++) begin
                tick4(c < hi);
            end
        end
    endtask

    task automatic run5(input int n, input int div, input int hi);
        for (int p = 0; p < n; p++) begin
            for (int c = 0; c < div; c++) begin
                @(negedge clk_in);
                clk_mon5 = (c < hi);
            end
        end
    endtask

    task automatic test_reset;
        rst_x = 1'b0; clk_mon4 = 1'b0; clk_mon5 = 1'b0; clr4 = 1'b0; clr5 = 1'b0;
        repeat (3) @(negedge clk_in);
        n_checks++; if (period4 !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_period: got %0d expected 0", period4); end
        n_checks++; if (high_time4 !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_high_time: got %0d expected 0", high_time4); end
        n_checks++; if (meas_vld4 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_meas_vld: got %b expected 0", meas_vld4); end
        n_checks++; if (lock4 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_lock: got %b expected 0", lock4); end
        n_checks++; if (fault4 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_fault: got %b expected 0", fault4); end
        n_checks++; if (err_cnt4 !== 8'd0) begin n_fail++; $display("[TB] FAIL reset_err_cnt: got %0d expected 0", err_cnt4); end
        n_checks++; if (lock5 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_lock5: got %b expected 0", lock5); end
        rst_x = 1'b1;
        repeat (3) tick4(1'b0);
    endtask

    task automatic test_divide4;
        q4.delete();
        run4(8, 4, 2);
        n_checks++; if (q4.size() != 7) begin n_fail++; $display("[TB] FAIL div4_count: got %0d expected 7", q4.size()); end
        for (int i = 0; i < q4.size(); i++) begin
            n_checks++; if (q4[i].per !== 8'd4) begin n_fail++; $display("[TB] FAIL div4_period[%0d]: got %0d expected 4", i, q4[i].per); end
            n_checks++; if (q4[i].hi !== 8'd2) begin n_fail++; $display("[TB] FAIL div4_high[%0d]: got %0d expected 2", i, q4[i].hi); end
            n_checks++; if (q4[i].lk !== (i >= 3)) begin n_fail++; $display("[TB] FAIL div4_lock[%0d]: got %b expected %b", i, q4[i].lk, (i >= 3)); end
            n_checks++; if (q4[i].err !== 8'd0) begin n_fail++; $display("[TB] FAIL div4_err[%0d]: got %0d expected 0", i, q4[i].err); end
            if (i > 0) begin
                n_checks++; if (q4[i].cyc - q4[i-1].cyc != 4) begin n_fail++; $display("[TB] FAIL div4_spacing[%0d]: got %0d expected 4", i, q4[i].cyc - q4[i-1].cyc); end
            end
        end
    endtask

    task automatic test_stretch;
        int exp_per[6] = '{4, 5, 4, 4, 4, 4};
        int exp_lk[6]  = '{1, 0, 0, 0, 0, 1};
        int exp_err[6] = '{0, 1, 1, 1, 1, 1};
        q4.delete();
        run4(1, 5, 2);
        run4(5, 4, 2);
        n_checks++; if (q4.size() != 6) begin n_fail++; $display("[TB] FAIL stretch_count: got %0d expected 6", q4.size()); end
        for (int i = 0; i < q4.size() && i < 6; i++) begin
            n_checks++; if (q4[i].per !== 8'(exp_per[i])) begin n_fail++; $display("[TB] FAIL stretch_period[%0d]: got %0d expected %0d", i, q4[i].per, exp_per[i]); end
            n_checks++; if (q4[i].hi !== 8'd2) begin n_fail++; $display("[TB] FAIL stretch_high[%0d]: got %0d expected 2", i, q4[i].hi); end
            n_checks++; if (q4[i].lk !== 1'(exp_lk[i])) begin n_fail++; $display("[TB] FAIL stretch_lock[%0d]: got %b expected %0d", i, q4[i].lk, exp_lk[i]); end
            n_checks++; if (q4[i].err !== 8'(exp_err[i])) begin n_fail++; $display("[TB] FAIL stretch_err[%0d]: got %0d expected %0d", i, q4[i].err, exp_err[i]); end
        end
    endtask

    task automatic test_stall;
        bit found = 1'b0;
        int dt = 0;
        q4.delete();
        for (int i = 0; i < 300 && !found; i++) begin
            tick4(1'b0);
            if (fault4 === 1'b1) begin
                found = 1'b1;
                dt = cyc - last_cap4;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL stall_fault: got 0 expected 1 within 300 cycles"); end
        n_checks++; if (dt < 250 || dt > 260) begin n_fail++; $display("[TB] FAIL stall_delay: got %0d expected about 254", dt); end
        n_checks++; if (lock4 !== 1'b0) begin n_fail++; $display("[TB] FAIL stall_lock: got %b expected 0", lock4); end
        n_checks++; if (err_cnt4 !== 8'd2) begin n_fail++; $display("[TB] FAIL stall_err: got %0d expected 2", err_cnt4); end
        repeat (20) tick4(1'b0);
        n_checks++; if (err_cnt4 !== 8'd2) begin n_fail++; $display("[TB] FAIL stall_once: got %0d expected 2", err_cnt4); end
        n_checks++; if (fault4 !== 1'b1) begin n_fail++; $display("[TB] FAIL stall_sticky: got %b expected 1", fault4); end
        n_checks++; if (q4.size() != 0) begin n_fail++; $display("[TB] FAIL stall_no_capture: got %0d expected 0", q4.size()); end
        run4(5, 4, 2);
        n_checks++; if (q4.size() != 4) begin n_fail++; $display("[TB] FAIL restart_count: got %0d expected 4", q4.size()); end
        for (int i = 0; i < q4.size(); i++) begin
            n_checks++; if (q4[i].per !== 8'd4) begin n_fail++; $display("[TB] FAIL restart_period[%0d]: got %0d expected 4", i, q4[i].per); end
            n_checks++; if (q4[i].lk !== (i == 3)) begin n_fail++; $display("[TB] FAIL restart_lock[%0d]: got %b expected %b", i, q4[i].lk, (i == 3)); end
            n_checks++; if (q4[i].err !== 8'd2) begin n_fail++; $display("[TB] FAIL restart_err[%0d]: got %0d expected 2", i, q4[i].err); end
        end
    endtask

    task automatic test_clr;
        run4(1, 5, 2);
        tick4(1'b1);
        tick4(1'b1);
        tick4(1'b0);
        clr4 = 1'b1;
        tick4(1'b0);
        n_checks++; if (meas_vld4 !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_evt_vld: got %b expected 1", meas_vld4); end
        n_checks++; if (period4 !== 8'd5) begin n_fail++; $display("[TB] FAIL clr_evt_period: got %0d expected 5", period4); end
        n_checks++; if (err_cnt4 !== 8'd1) begin n_fail++; $display("[TB] FAIL clr_evt_err: got %0d expected 1", err_cnt4); end
        n_checks++; if (lock4 !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_evt_lock: got %b expected 0", lock4); end
        tick4(1'b0);
        clr4 = 1'b0;
        n_checks++; if (err_cnt4 !== 8'd0) begin n_fail++; $display("[TB] FAIL clr_alone_err: got %0d expected 0", err_cnt4); end
        n_checks++; if (fault4 !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_alone_fault: got %b expected 0", fault4); end
        n_checks++; if (period4 !== 8'd5) begin n_fail++; $display("[TB] FAIL clr_alone_period: got %0d expected 5", period4); end
    endtask

    task automatic test_saturation;
        run4(260, 5, 2);
        n_checks++; if (err_cnt4 !== 8'd255) begin n_fail++; $display("[TB] FAIL sat_err: got %0d expected 255", err_cnt4); end
        n_checks++; if (lock4 !== 1'b0) begin n_fail++; $display("[TB] FAIL sat_lock: got %b expected 0", lock4); end
        clr4 = 1'b1;
        tick4(1'b0);
        clr4 = 1'b0;
        n_checks++; if (err_cnt4 !== 8'd0) begin n_fail++; $display("[TB] FAIL sat_clr: got %0d expected 0", err_cnt4); end
    endtask

    task automatic test_div5;
        int exp_per[10] = '{5, 5, 5, 5, 5, 5, 6, 6, 6, 6};
        int exp_hi[10]  = '{2, 2, 2, 2, 2, 2, 3, 3, 3, 3};
        int exp_lk[10]  = '{0, 0, 0, 1, 1, 1, 0, 0, 0, 0};
        int exp_err[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 4};
        q5.delete();
        run5(6, 5, 2);
        run5(5, 6, 3);
        n_checks++; if (q5.size() != 10) begin n_fail++; $display("[TB] FAIL div5_count: got %0d expected 10", q5.size()); end
        for (int i = 0; i < q5.size() && i < 10; i++) begin
            n_checks++; if (q5[i].per !== 8'(exp_per[i])) begin n_fail++; $display("[TB] FAIL div5_period[%0d]: got %0d expected %0d", i, q5[i].per, exp_per[i]); end
            n_checks++; if (q5[i].hi !== 8'(exp_hi[i])) begin n_fail++; $display("[TB] FAIL div5_high[%0d]: got %0d expected %0d", i, q5[i].hi, exp_hi[i]); end
            n_checks++; if (q5[i].lk !== 1'(exp_lk[i])) begin n_fail++; $display("[TB] FAIL div5_lock[%0d]: got %b expected %0d", i, q5[i].lk, exp_lk[i]); end
            n_checks++; if (q5[i].err !== 8'(exp_err[i])) begin n_fail++; $display("[TB] FAIL div5_err[%0d]: got %0d expected %0d", i, q5[i].err, exp_err[i]); end
        end
    endtask

    task automatic test_reset_high;
        @(negedge clk_in);
        rst_x = 1'b0;
        clk_mon4 = 1'b1;
        repeat (3) @(negedge clk_in);
        rst_x = 1'b1;
        q4.delete();
        tick4(1'b1);
        tick4(1'b1);
        tick4(1'b0);
        tick4(1'b0);
        run4(3, 4, 2);
        n_checks++; if (q4.size() != 2) begin n_fail++; $display("[TB] FAIL rsthigh_count: got %0d expected 2", q4.size()); end
        if (q4.size() > 0) begin
            n_checks++; if (q4[0].per !== 8'd4) begin n_fail++; $display("[TB] FAIL rsthigh_first_period: got %0d expected 4", q4[0].per); end
        end
        run4(3, 4, 2);
        n_checks++; if (lock4 !== 1'b1) begin n_fail++; $display("[TB] FAIL rsthigh_lock: got %b expected 1", lock4); end
        @(negedge clk_in);
        #2;
        rst_x = 1'b0;
        #1;
        n_checks++; if (lock4 !== 1'b0) begin n_fail++; $display("[TB] FAIL async_lock: got %b expected 0", lock4); end
        n_checks++; if (period4 !== 8'd0) begin n_fail++; $display("[TB] FAIL async_period: got %0d expected 0", period4); end
        n_checks++; if (high_time4 !== 8'd0) begin n_fail++; $display("[TB] FAIL async_high_time: got %0d expected 0", high_time4); end
        n_checks++; if (meas_vld4 !== 1'b0) begin n_fail++; $display("[TB] FAIL async_meas_vld: got %b expected 0", meas_vld4); end
        n_checks++; if (fault4 !== 1'b0) begin n_fail++; $display("[TB] FAIL async_fault: got %b expected 0", fault4); end
        n_checks++; if (err_cnt4 !== 8'd0) begin n_fail++; $display("[TB] FAIL async_err: got %0d expected 0", err_cnt4); end
    endtask

    // Scenario sequence
    initial begin
        test_reset();
        test_divide4();
        test_stretch();
        test_stall();
        test_clr();
        test_saturation();
        test_div5();
        test_reset_high();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clock_div_monitor.md
# clock_div_monitor

Measures a divided clock in the source clock domain and checks it against an expected division factor. Each rising edge of the monitored signal produces a period and high-time measurement. The block then reports lock, error count and a stall fault. It is the checking end of the clock divider: it sits beside each divided clock in the clock generator core and gives BIST and status registers a health indication.

## Interface
- cfactor, 4: expected division factor; legal range 2..(2^CNT_W − 2 − TOL).
- TOL, 0: allowed ± deviation, in clk_in cycles, for both period and high time.
- LOCK_N, 4: consecutive good measurements required to assert lock; range 1..15.
- CNT_W, 8: width of the measurement counters.

Ports:
- clk_in  in  1  source clock; all logic runs on its rising edge.
- rst_x  in  1  asynchronous, active-low reset.
- clk_mon  in  1  divided clock under test; treated as asynchronous.
- clr  in  1  synchronous clear of err_cnt and fault.
- period  out  CNT_W  last measured period in clk_in cycles, rising edge to rising edge.
- high_time  out  CNT_W  last measured high time in clk_in cycles.
- meas_vld  out  1  one-cycle pulse when period and high_time update.
- lock  out  1  clock within tolerance for at least LOCK_N consecutive periods.
- fault  out  1  sticky: stall timeout seen.
- err_cnt  out  8  saturating count of bad measurements and timeouts.

## Operation
**Synchronizer and edge detection**
- clk_mon passes through flops s1 and s2, then s3 as the edge-history flop.
- All three reset to 1, so a high clk_mon at reset release is not seen as a rising edge.
- rise = s2 & ~s3.

**Counters** (registered, width CNT_W, saturating at MAX = 2^CNT_W − 1)
- per_cnt: set to 1 on rise, otherwise increments.
- hi_cnt: set to 1 on rise, otherwise increments while s2 = 1 and holds while s2 = 0.

**Measurement check**
- good = (|per_cnt − cfactor| ≤ TOL) and (|hi_cnt − cfactor/2| ≤ TOL).
- cfactor/2 uses integer division, so odd N expects floor(N/2) high cycles.

**State machine**
- IDLE: no reference edge yet. On rise: reset the counters, make no capture, go to MEAS.
- MEAS: on rise, capture period ← per_cnt and high_time ← hi_cnt, and pulse meas_vld.
  - If good: good_cnt++. When good_cnt reaches LOCK_N, set lock and go to LOCK.
  - If bad: good_cnt ← 0 and err_cnt++.
- LOCK: on rise, capture as in MEAS.
  - If good: stay in LOCK.
  - If bad: lock ← 0, good_cnt ← 0, err_cnt++, go to MEAS.
- Timeout, in MEAS or LOCK, when per_cnt = MAX with no rise:
  - Set fault, lock ← 0, good_cnt ← 0, err_cnt++, go to IDLE.
  - This fires once only: IDLE does not re-trigger it.

**Boundary rules**
- rise and per_cnt = MAX in the same cycle: this is a capture of MAX, which is a bad measurement, not a timeout.
- clr in the same cycle as an error event: the event wins, giving err_cnt = 1, and fault is set if the event is a timeout.
- clr with no event: err_cnt ← 0 and fault ← 0. lock, state and the measurements are unaffected.
- err_cnt saturates at 255.
- Asynchronous reset mid-measurement returns everything to reset values. The first rise after release only arms the block.

## Timing
**Reset values**
- period 0, high_time 0, meas_vld 0, lock 0, fault 0, err_cnt 0.
- State IDLE, good_cnt 0, s1, s2 and s3 all at 1.

**Latency**
- Let clk_in edge k be the edge that launches a clk_mon rise.
- rise is true in the cycle after edge k+2.
- period, high_time, meas_vld, lock and err_cnt update at edge k+3.
- This offset is constant, so measured values equal the true cycle counts.

**Update timing**
- meas_vld is high for exactly one cycle per captured period. It is never asserted in IDLE.
- lock rises on the same edge as the meas_vld of the LOCK_N-th consecutive good measurement.
- lock falls on the edge of the bad capture, or on the timeout edge.
- The timeout edge is 2^CNT_W − 2 clk_in cycles after the last rise was registered.

## Test plan
1. Default parameters, clk_mon from a divide-by-4 divider -> meas_vld every 4 cycles with period=4 and high_time=2. lock rises on the 4th meas_vld after the arming edge. err_cnt stays 0.
2. cfactor=5, divide-by-5 source -> period=5, high_time=2, lock asserted. Repeat with TOL=0 and a divide-by-6 source -> err_cnt increments once per period, lock stays 0.
3. Locked at divide-by-4, then one stretched period of 5 cycles -> lock drops at that capture and err_cnt=1. lock returns after 4 further good periods.
4. Locked, then clk_mon held low -> after 254 cycles without an edge, fault=1, lock=0 and err_cnt increments by 1. Restart the clock -> the first rise only arms; lock returns after 4 good periods.
5. clr pulsed on the same edge as a bad capture -> err_cnt=1. clr alone next cycle -> err_cnt=0 and fault=0.
6. Reset with clk_mon held high, then release and run divide-by-4 -> no meas_vld until the second genuine rising edge. Assert rst_x while locked -> all outputs return to 0 asynchronously.
